writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 4: write-queue entries; power of two, at least 2.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have ports alu_valid, alu_rd, alu_data, alu_cond, inputs, 1/4/32/4: ALU result, destination register, value, instruction condition field.
REQ-005 SHALL have ports mem_valid, mem_rd, mem_data, mem_cond, inputs, 1/4/32/4: load-return result, same fields.
REQ-006 SHALL have port flags, input, 4: current NZCV, bit3=N, bit2=Z, bit1=C, bit0=V.
REQ-007 SHALL have port in_ready, output, 1: both producers may present results this cycle.
REQ-008 SHALL have ports r_write, rd_write, data_in, outputs, 1/4/32: register-file write port driving the decode stage.
REQ-009 SHALL have ports fwd_rd, input, 4, and fwd_hit, output, 1, and fwd_data, output, 32: pending-write lookup.

Function
REQ-010 A result SHALL be accepted when its valid and in_ready are both high in the same cycle.
REQ-011 in_ready SHALL be high exactly when queue occupancy is at most DEPTH-2, so two results always fit.
REQ-012 Valid asserted while in_ready is low SHALL be ignored; producers hold their result until accepted.
REQ-013 Condition is evaluated at acceptance against flags: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
REQ-014 A condition-failed result SHALL be discarded and SHALL NOT be enqueued.
REQ-015 When both results pass in the same cycle, the ALU entry SHALL be enqueued before the mem entry.
REQ-016 The queue SHALL be FIFO with wrap-around pointers of width log2(DEPTH) and an occupancy counter of width log2(DEPTH)+1.
REQ-017 Each cycle with a non-empty queue, the head SHALL be popped into registered outputs: r_write=1, rd_write=head rd, data_in=head data.
REQ-018 When the queue is empty, r_write SHALL be 0; rd_write and data_in hold their last values.
REQ-019 Latency SHALL be 1 cycle: an entry accepted at edge k into an empty queue is presented from edge k to edge k+1.
REQ-020 Simultaneous pop and one or two pushes SHALL update occupancy by (pushes - 1) in a single cycle.
REQ-021 Two queued entries with the same rd SHALL both be written, in order; no merging.

Reset
REQ-022 While rst_n is low: occupancy 0, pointers 0, r_write 0, rd_write 0, data_in 0, in_ready 1.
REQ-023 Reset asserted mid-operation SHALL discard all queued entries; no write issues on the first edge after release.

Configuration
REQ-024 Macro WB_FORWARD_EN defined: fwd_hit=1 when fwd_rd matches the rd of any queued entry or of the currently presented write with r_write=1; fwd_data is the youngest match. This path is combinational.
REQ-025 WB_FORWARD_EN undefined: fwd_hit and fwd_data SHALL be tied to 0 and no comparison logic is built.

Structure
REQ-026 A shared package SHALL hold the condition-code constants (EQ..NV), the NZCV bit indices, and the queue-entry typedef {rd[3:0], data[31:0]}.
REQ-027 Condition evaluation SHALL be one sub-module, cond_eval (cond, flags -> pass), reusable by the execute stage.

Verification
REQ-028 Scenario: reset, then alu_valid with rd=3, data=0x12345678, cond=E -> next cycle r_write=1, rd_write=3, data_in=0x12345678, then r_write=0.
REQ-029 Scenario: flags Z=1; alu cond=1 (NE) and mem cond=0 (EQ), rd=5, data=0xAA, same cycle -> only one write, rd 5 / 0xAA.
REQ-030 Scenario: both producers valid and passing for 3 consecutive cycles with DEPTH=4 -> in_ready falls once occupancy reaches 3; writes appear in order ALU0, MEM0, ALU1, MEM1...; none lost.
REQ-031 Scenario: cond=F on any result -> never written; cond=A with N=1, V=1 -> written.
REQ-032 Scenario: rst_n pulsed low with 3 entries queued -> r_write=0 immediately; no stale writes after release.
REQ-033 Scenario (WB_FORWARD_EN): queue holds rd=7 data 0x1 then rd=7 data 0x2; fwd_rd=7 -> fwd_hit=1, fwd_data=0x2; fwd_rd=8 -> fwd_hit=0.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// rtl/writeback_stage_pkg.sv - shared condition codes, NZCV indices and write-queue entry type
package writeback_stage_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_stage_cond_eval.sv
// rtl/writeback_stage_cond_eval.sv - condition field vs NZCV pass/fail, shared with execute
module cond_eval
  import writeback_stage_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - conditional ALU/load result write queue feeding the register file
// Define WB_FORWARD_EN to build the pending-write lookup (fwd_rd -> fwd_hit/fwd_data).
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [3:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic [3:0]  alu_cond,
  input  logic        mem_valid,
  input  logic [3:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic [3:0]  mem_cond,
  input  logic [3:0]  flags,
  output logic        in_ready,
  output logic        r_write,
  output logic [3:0]  rd_write,
  output logic [31:0] data_in,
  input  logic [3:0]  fwd_rd,
  output logic        fwd_hit,
  output logic [31:0] fwd_data
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t     queue_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nx;
  logic [PW:0]   occ;
  logic          alu_pass, mem_pass, alu_push, mem_push, avail;
  logic [1:0]    n_push;
  wb_entry_t     alu_entry, mem_entry, first_push, head;

  cond_eval u_alu_cond (.cond(alu_cond), .flags(flags), .pass(alu_pass));
  cond_eval u_mem_cond (.cond(mem_cond), .flags(flags), .pass(mem_pass));

  assign in_ready  = (occ <= (PW+1)'(DEPTH - 2));
  assign alu_push  = alu_valid && in_ready && alu_pass;
  assign mem_push  = mem_valid && in_ready && mem_pass;
  assign n_push    = {1'b0, alu_push} + {1'b0, mem_push};
  assign alu_entry = '{rd: alu_rd, data: alu_data};
  assign mem_entry = '{rd: mem_rd, data: mem_data};
  assign wr_ptr_nx = wr_ptr + PW'(1);

  // Pushes are always stored; when the queue was empty the first push also
  // bypasses straight to the output so latency stays at one edge.
  always_comb begin
    first_push = alu_push ? alu_entry : mem_entry;
    head       = (occ != '0) ? queue_mem[rd_ptr] : first_push;
    avail      = (occ != '0) || (n_push != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (n_push != 2'd0) queue_mem[wr_ptr] <= first_push;
    if (n_push == 2'd2) queue_mem[wr_ptr_nx] <= mem_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      r_write  <= 1'b0;
      rd_write <= '0;
      data_in  <= '0;
    end else begin
      wr_ptr  <= wr_ptr + PW'(n_push);
      rd_ptr  <= rd_ptr + PW'(avail);
      occ     <= occ + (PW+1)'(n_push) - (PW+1)'(avail);
      r_write <= avail;
      if (avail) begin
        rd_write <= head.rd;
        data_in  <= head.data;
      end
    end
  end

`ifdef WB_FORWARD_EN
  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (r_write && (rd_write == fwd_rd)) begin
      fwd_hit  = 1'b1;
      fwd_data = data_in;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (((PW+1)'(i) < occ) && (queue_mem[rd_ptr + PW'(i)].rd == fwd_rd)) begin
        fwd_hit  = 1'b1;
        fwd_data = queue_mem[rd_ptr + PW'(i)].data;
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - scoreboard bench for writeback_stage with directed vectors
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic [3:0]  alu_rd = '0, mem_rd = '0, alu_cond = '0, mem_cond = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic [3:0]  flags = '0, fwd_rd = '0;
  logic        in_ready, r_write, fwd_hit;
  logic [3:0]  rd_write;
  logic [31:0] data_in, fwd_data;

  logic [35:0] sb[$];
  logic [35:0] exp_e;
  int n_checks = 0;
  int n_fail   = 0;

  writeback_stage #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_cond(alu_cond),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_cond(mem_cond),
    .flags(flags), .in_ready(in_ready),
    .r_write(r_write), .rd_write(rd_write), .data_in(data_in),
    .fwd_rd(fwd_rd), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && r_write) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got rd %0d data %h expected no write", rd_write, data_in);
      end else begin
        exp_e = sb.pop_front();
        check("wb_rd", {28'd0, rd_write}, {28'd0, exp_e[35:32]});
        check("wb_data", data_in, exp_e[31:0]);
      end
    end
  end

  // aexp/mexp: hand-computed condition outcome for each producer
  task automatic issue(input logic av, input logic [3:0] ard, input logic [31:0] ad,
                       input logic [3:0] ac, input logic aexp,
                       input logic mv, input logic [3:0] mrd, input logic [31:0] md,
                       input logic [3:0] mc, input logic mexp, input logic [3:0] fl);
    int waitc;
    flags = fl;
    alu_valid = av; alu_rd = ard; alu_data = ad; alu_cond = ac;
    mem_valid = mv; mem_rd = mrd; mem_data = md; mem_cond = mc;
    waitc = 0;
    while (!in_ready && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: in_ready got 0 expected 1");
    end else begin
      if (av && aexp) sb.push_back({ard, ad});
      if (mv && mexp) sb.push_back({mrd, md});
    end
    @(posedge clk); #1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic drain();
    int waitc;
    waitc = 0;
    while (sb.size() != 0 && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2;
    check("rst_r_write", {31'd0, r_write}, 32'd0);
    check("rst_rd_write", {28'd0, rd_write}, 32'd0);
    check("rst_data_in", data_in, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single ALU write, one-cycle presentation then idle with held outputs
    issue(1, 4'd3, 32'h12345678, 4'hE, 1, 0, 4'd0, 32'd0, 4'hE, 0, 4'b0000);
    check("single_r_write", {31'd0, r_write}, 32'd1);
    @(posedge clk); #1;
    check("idle_r_write", {31'd0, r_write}, 32'd0);
    check("idle_rd_hold", {28'd0, rd_write}, 32'd3);
    check("idle_data_hold", data_in, 32'h12345678);

    // condition evaluation vectors
    issue(1, 4'd5, 32'hBB, 4'h1, 0, 1, 4'd5, 32'hAA, 4'h0, 1, 4'b0100);
    issue(1, 4'd9, 32'h99, 4'hF, 0, 1, 4'd10, 32'h10, 4'hA, 1, 4'b1001);
    issue(1, 4'd1, 32'h11, 4'h8, 1, 1, 4'd2, 32'h22, 4'hB, 0, 4'b0010);
    issue(1, 4'd3, 32'h33, 4'hC, 0, 1, 4'd4, 32'h44, 4'hD, 1, 4'b1000);
    issue(1, 4'd6, 32'h66, 4'h3, 1, 1, 4'd7, 32'h77, 4'h6, 0, 4'b0000);
    issue(0, 4'd8, 32'h88, 4'hE, 1, 1, 4'd8, 32'h8F, 4'hF, 0, 4'b0000);
    drain();

    // back-to-back pairs fill the queue until in_ready drops
    issue(1, 4'd1, 32'hA0, 4'hE, 1, 1, 4'd2, 32'hB0, 4'hE, 1, 4'b0000);
    issue(1, 4'd3, 32'hA1, 4'hE, 1, 1, 4'd4, 32'hB1, 4'hE, 1, 4'b0000);
    issue(1, 4'd5, 32'hA2, 4'hE, 1, 1, 4'd6, 32'hB2, 4'hE, 1, 4'b0000);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    issue(1, 4'd7, 32'hA3, 4'hE, 1, 1, 4'd8, 32'hB3, 4'hE, 1, 4'b0000);
    drain();

    // same rd twice stays queued in order; lookup sees youngest
    issue(1, 4'd1, 32'h1, 4'hE, 1, 1, 4'd2, 32'h2, 4'hE, 1, 4'b0000);
    issue(1, 4'd7, 32'h1, 4'hE, 1, 1, 4'd7, 32'h2, 4'hE, 1, 4'b0000);
    fwd_rd = 4'd7;
    #1;
`ifdef WB_FORWARD_EN
    check("fwd_hit_7", {31'd0, fwd_hit}, 32'd1);
    check("fwd_data_7", fwd_data, 32'h2);
`else
    check("fwd_hit_off", {31'd0, fwd_hit}, 32'd0);
    check("fwd_data_off", fwd_data, 32'd0);
`endif
    fwd_rd = 4'd8;
    #1;
    check("fwd_hit_8", {31'd0, fwd_hit}, 32'd0);
    drain();

    // reset mid-operation with three entries queued
    issue(1, 4'd1, 32'hC0, 4'hE, 1, 1, 4'd2, 32'hD0, 4'hE, 1, 4'b0000);
    issue(1, 4'd3, 32'hC1, 4'hE, 1, 1, 4'd4, 32'hD1, 4'hE, 1, 4'b0000);
    issue(1, 4'd5, 32'hC2, 4'hE, 1, 1, 4'd6, 32'hD2, 4'hE, 1, 4'b0000);
    rst_n = 1'b0;
    #1;
    check("midrst_r_write", {31'd0, r_write}, 32'd0);
    check("midrst_data_in", data_in, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_write", {31'd0, r_write}, 32'd0);
    end

    issue(0, 4'd0, 32'd0, 4'hE, 0, 1, 4'd4, 32'hCAFE, 4'hE, 1, 4'b0000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
